// File: rtl/llr_fmt_pkg.sv
// llr_fmt_pkg: mode encodings, sat counter width and magnitude clip helper shared by the LLR converter
package llr_fmt_pkg;
    localparam logic MODE_T2S = 1'b0;
    localparam logic MODE_S2T = 1'b1;
    localparam int SAT_CNT_W = 16;
    function automatic logic [31:0] sat_mag(input logic [31:0] mag, input int mag_width);
        logic [31:0] lim;
        lim = (32'd1 << mag_width) - 32'd1;
        return mag > lim ? lim : mag;
    endfunction
endpackage

// File: rtl/llr_fmt_lane.sv
// llr_fmt_lane: per-lane sign/magnitude split (first half) and clip/pack (second half), both combinational
module llr_fmt_lane
    import llr_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int MAG_WIDTH  = 5
) (
    input  logic [DATA_WIDTH-1:0] raw,
    input  logic                  raw_mode,
    output logic                  sign,
    output logic [DATA_WIDTH-1:0] mag,
    input  logic                  s_sign,
    input  logic [DATA_WIDTH-1:0] s_mag,
    input  logic                  s_mode,
    output logic [MAG_WIDTH:0]    pack,
    output logic                  sat
);
    logic [MAG_WIDTH-1:0] clip;
    logic [MAG_WIDTH:0]   ext;
    always_comb begin
        sign = raw[DATA_WIDTH-1];
        // |most negative| still fits because mag is treated as unsigned
        mag  = raw_mode == MODE_S2T ? {1'b0, raw[DATA_WIDTH-2:0]} : (sign ? -raw : raw);
        clip = MAG_WIDTH'(sat_mag(32'(s_mag), MAG_WIDTH));
        sat  = 32'(clip) != 32'(s_mag);
        ext  = {1'b0, clip};
        pack = s_mode == MODE_S2T ? (s_sign ? -ext : ext) : {s_sign, clip};
    end
endmodule

// File: rtl/llr_fmt_conv.sv
// llr_fmt_conv: two-stage multi-lane T2S/S2T LLR converter with saturation and valid/ready flow control.
// Define LLR_FMT_SAT_CNT_EN to add the saturated-lane counter (sat_cnt_clr, sat_cnt).
module llr_fmt_conv
    import llr_fmt_pkg::*;
#(
    parameter int DATA_WIDTH = 6,
    parameter int MAG_WIDTH  = 5,
    parameter int LANES      = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode,
    input  logic [LANES*DATA_WIDTH-1:0]    in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES*(MAG_WIDTH+1)-1:0] out_data,
`ifdef LLR_FMT_SAT_CNT_EN
    input  logic                           sat_cnt_clr,
    output logic [SAT_CNT_W-1:0]           sat_cnt,
`endif
    output logic [LANES-1:0]               out_sat
);
    logic                                 s1_valid, s1_mode, s2_valid, s1_load, s2_load;
    logic [LANES-1:0]                     sign_d, sign_q, sat_d, sat_q;
    logic [LANES-1:0][DATA_WIDTH-1:0]     mag_d, mag_q;
    logic [LANES*(MAG_WIDTH+1)-1:0]       pack_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        llr_fmt_lane #(.DATA_WIDTH(DATA_WIDTH), .MAG_WIDTH(MAG_WIDTH)) u_lane (
            .raw      (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .raw_mode (in_mode),
            .sign     (sign_d[i]),
            .mag      (mag_d[i]),
            .s_sign   (sign_q[i]),
            .s_mag    (mag_q[i]),
            .s_mode   (s1_mode),
            .pack     (pack_d[i*(MAG_WIDTH+1) +: MAG_WIDTH+1]),
            .sat      (sat_d[i])
        );
    end

    always_comb begin
        s2_load   = !s2_valid || out_ready;
        s1_load   = !s1_valid || s2_load;
        in_ready  = s1_load;
        out_valid = s2_valid;
        out_sat   = s2_valid ? sat_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            out_data <= '0;
            sat_q    <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                s1_mode  <= in_mode;
                sign_q   <= sign_d;
                mag_q    <= mag_d;
            end
            if (s2_load) s2_valid <= s1_valid;
            // an idle S2 keeps its last word; only real beats overwrite it
            if (s2_load && s1_valid) begin
                out_data <= pack_d;
                sat_q    <= sat_d;
            end
        end
    end

`ifdef LLR_FMT_SAT_CNT_EN
    localparam int CW = SAT_CNT_W + 1;
    logic [SAT_CNT_W:0] cnt_sum;
    always_comb cnt_sum = {1'b0, sat_cnt} + CW'($countones(out_sat));
    always_ff @(posedge clk) begin
        if (!rst_n || sat_cnt_clr) sat_cnt <= '0;
        else if (out_valid && out_ready) sat_cnt <= cnt_sum[SAT_CNT_W] ? '1 : cnt_sum[SAT_CNT_W-1:0];
    end
`endif
endmodule

// File: doc/llr_fmt_conv.md
Name: llr_fmt_conv

Overview:
- Multi-lane, pipelined LLR format converter for the LDPC decoder datapath, successor to the single-lane combinational two's-complement-to-sign-magnitude utility.
- Converts LANES values per beat in either direction, two's complement to sign-magnitude or sign-magnitude to two's complement, selected per beat.
- Saturates magnitudes to a configurable message width.
- Sits between channel-LLR input and the check/variable-node message memories; uses a valid/ready handshake with full backpressure.

Parameters:
- DATA_WIDTH, 6: input bits per lane.
- MAG_WIDTH, 5: output magnitude bits; each output lane is MAG_WIDTH+1 bits. Legal range 1..DATA_WIDTH.
- LANES, 4: values per beat.

Ports:
- clk  in  1: clock.
- rst_n  in  1: reset. Synchronous, active-low. One clock; all state updates on the rising edge of clk.
- in_valid  in  1: input beat valid.
- in_ready  out  1: block accepts the beat when in_valid && in_ready.
- in_mode  in  1: 0 = T2S (two's complement in), 1 = S2T (sign-magnitude in). Sampled with the beat.
- in_data  in  LANES*DATA_WIDTH: lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1: output beat valid.
- out_ready  in  1: downstream accepts when out_valid && out_ready.
- out_data  out  LANES*(MAG_WIDTH+1): lane i at bits [i*(MAG_WIDTH+1) +: MAG_WIDTH+1].
- out_sat  out  LANES: per-lane flag, set when the lane magnitude was clipped.

Behaviour:
- Reset (rst_n=0 at the clk edge): both stage valids clear; out_valid=0, out_data=0, out_sat=0. in_ready=1 from the first cycle after reset. Beats in flight are discarded. Reset takes priority over any simultaneous handshake.
- Pipeline: two register stages, S1 and S2. S2 drives the outputs.
  - S1: per-lane sign and full magnitude.
  - S2: saturation, then packing.
- Latency: a beat accepted at edge N is presented at edge N+2 when out_ready=1. Throughput is one beat per cycle.
- Flow control: S2 loads when it is empty or out_ready=1. S1 loads when it is empty or S2 loads. in_ready = !s1_valid || s2_load, i.e. combinational from state and out_ready.
  - With out_ready low, two beats are held and then in_ready=0.
  - No beat is lost or duplicated; order is preserved.
  - out_data and out_valid are stable while out_valid && !out_ready.
- The mode bit travels with its beat, so a mode change between consecutive beats needs no bubble.
- T2S per lane:
  - Input v is signed DATA_WIDTH bits.
  - sign = v<0. mag = |v|, computed in DATA_WIDTH bits unsigned; |-2^(DATA_WIDTH-1)| = 2^(DATA_WIDTH-1) is representable.
  - If mag > 2^MAG_WIDTH-1: mag := 2^MAG_WIDTH-1 and sat=1.
  - Output = {sign, mag}. Zero yields sign 0.
- S2T per lane:
  - Input is {s, m}, where m is DATA_WIDTH-1 bits.
  - m clipped to 2^MAG_WIDTH-1 with sat=1 if clipped.
  - Output = s ? -m : m, as MAG_WIDTH+1 bit two's complement.
  - Negative zero (s=1, m=0) maps to 0, sat=0.
- out_sat is valid only with out_valid; it is 0 otherwise.
- Idle S2 holds its last out_data. Only out_valid is meaningful.

Optional Feature:
- Macro: LLR_FMT_SAT_CNT_EN.
- When defined, adds ports:
  - sat_cnt_clr  in  1
  - sat_cnt  out  16
- sat_cnt accumulates popcount(out_sat) on each output handshake and saturates at 16'hFFFF.
- sat_cnt_clr=1 sets it to 0 on that edge and overrides any same-cycle increment.
- Reset value of sat_cnt is 0.
- When the macro is undefined, neither port nor the counter exists; the datapath is identical.

Decomposition:
- Package llr_fmt_pkg holds:
  - MODE_T2S=1'b0, MODE_S2T=1'b1
  - SAT_CNT_W=16
  - function sat_mag(mag, MAG_WIDTH)
- Sub-module llr_fmt_lane: per-lane sign/magnitude extraction (S1 logic) plus saturation/pack (S2 logic), split into two combinational halves. Instantiated LANES times under a generate loop.
- Handshake and pipeline registers live in the top module.

Test Plan:
- Defaults, T2S, out_ready=1, lanes {-32,-5,0,31} -> after 2 cycles: lane0 6'b111111 sat=1, lane1 6'b100101, lane2 6'b000000, lane3 6'b011111; out_sat=4'b0001.
- S2T, lanes {6'b100111, 6'b100000, 6'b011111, 6'b000011} -> lane0 6'b111001 (-7), lane1 6'b000000 (negative zero), lane2 6'b011111 sat=0, lane3 6'b000011.
- Exhaustive: all 64 codes per lane in both modes, compared against the reference model (T2S at MAG_WIDTH=DATA_WIDTH must match the legacy 7-bit converter's magnitude/sign).
- Backpressure: continuous input, out_ready low for cycles 3-7 -> in_ready=0 after two beats are held, out_data stable, all 10 beats delivered in order; alternating mode per beat verified.
- Reset mid-stream with two beats in flight -> out_valid=0 next cycle, in_ready=1, no stale beat emitted.
- LLR_FMT_SAT_CNT_EN: 3 beats each with 2 saturated lanes -> sat_cnt=6; clr asserted together with a saturating handshake -> sat_cnt=0; preload near 16'hFFFF -> holds 16'hFFFF.
